// File: rtl/if_fetch_pkg.sv
// Shared configuration for the instruction-fetch slice: widths, reset level,
// fetch-state encodings and stall-vector bit positions.
package if_fetch_pkg;

  localparam int Addrlen    = 32;
  localparam int Instlen    = 32;
  localparam int StallWidth = 6;

  typedef logic [Addrlen-1:0] addr_t;
  typedef logic [Instlen-1:0] inst_t;

  localparam inst_t ZeroWord    = '0;
  localparam logic  ResetEnable = 1'b0;
  localparam addr_t PcStep      = 32'd4;

  localparam logic [1:0] IF_IDLE    = 2'd0;
  localparam logic [1:0] IF_WAIT    = 2'd1;
  localparam logic [1:0] IF_DONE    = 2'd2;
  localparam logic [1:0] IF_DISCARD = 2'd3;

  localparam int StallPc = 0;
  localparam int StallIf = 1;

  function automatic addr_t word_align(input addr_t a);
    return {a[Addrlen-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-side memory bus: word request held until ack, returned data valid with ack.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic  mem_req;
  addr_t mem_addr;
  logic  mem_ack;
  inst_t mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup with tag compare,
// single write port filled from completed memory fetches.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic  clk,
  input  logic  rst,
  input  addr_t lookup_addr,
  output logic  hit,
  output inst_t rdata,
  input  logic  write_en,
  input  addr_t write_addr,
  input  inst_t write_data
);

  localparam int IdxW = $clog2(LINES);
  localparam int TagW = Addrlen - IdxW - 2;

  logic [LINES-1:0] valid;
  logic [TagW-1:0]  tags [LINES];
  inst_t            data [LINES];

  logic [IdxW-1:0] rd_idx;
  logic [IdxW-1:0] wr_idx;
  logic [TagW-1:0] rd_tag;
  logic [TagW-1:0] wr_tag;
  logic            unused_bits;

  assign rd_idx      = lookup_addr[IdxW+1:2];
  assign rd_tag      = lookup_addr[Addrlen-1:IdxW+2];
  assign wr_idx      = write_addr[IdxW+1:2];
  assign wr_tag      = write_addr[Addrlen-1:IdxW+2];
  assign unused_bits = ^{lookup_addr[1:0], write_addr[1:0]};

  assign hit   = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rdata = data[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == ResetEnable) begin
      valid <= '0;
    end else if (write_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data storage has no reset; the valid bits alone qualify a hit,
  // which keeps the arrays mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= write_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, requests words from memory and
// presents pc/inst to IF/ID. Define IF_ICACHE_EN to add a direct-mapped I-cache.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC     = 32'h0000_0000,
  parameter int    ICACHE_LINES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [StallWidth-1:0] stall,
  input  logic                  jump_flag,
  input  addr_t                 jump_target,
  if_fetch_if.master            mem,
  output logic                  stallreq_if,
  output addr_t                 if_pc,
  output inst_t                 if_inst
);

  logic [1:0] state;
  addr_t      pc;
  addr_t      mem_addr_q;
  addr_t      redirect_pc;
  inst_t      inst_buf;
  inst_t      cache_rdata;
  logic       mem_req_q;
  logic       cache_hit;
  logic       unused_bits;

  assign redirect_pc  = word_align(jump_target);
  assign unused_bits  = ^{stall[StallWidth-1:StallIf], jump_target[1:0]};
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

`ifdef IF_ICACHE_EN
  logic cache_we;

  // Only an ack that completes a live fetch fills a line; redirect-dropped data never does.
  assign cache_we = rdy && (state == IF_WAIT) && mem.mem_ack && !jump_flag;

  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(pc),
    .hit        (cache_hit),
    .rdata      (cache_rdata),
    .write_en   (cache_we),
    .write_addr (mem_addr_q),
    .write_data (mem.mem_rdata)
  );
`else
  logic unused_cfg;

  assign cache_hit   = 1'b0;
  assign cache_rdata = ZeroWord;
  assign unused_cfg  = ICACHE_LINES[0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every branch
  // below reads the pre-edge values of pc/state.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == ResetEnable) begin
      state      <= IF_IDLE;
      pc         <= RESET_PC;
      inst_buf   <= ZeroWord;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy) begin
      if (jump_flag) begin
        pc <= redirect_pc;
        case (state)
          IF_WAIT, IF_DISCARD: begin
            // An in-flight request must still be retired before refetching.
            if (mem.mem_ack) begin
              mem_req_q <= 1'b0;
              state     <= IF_IDLE;
            end else begin
              state     <= IF_DISCARD;
            end
          end
          default: state <= IF_IDLE;
        endcase
      end else begin
        case (state)
          IF_IDLE: begin
            if (cache_hit) begin
              inst_buf <= cache_rdata;
              state    <= IF_DONE;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= word_align(pc);
              state      <= IF_WAIT;
            end
          end
          IF_WAIT: begin
            if (mem.mem_ack) begin
              inst_buf  <= mem.mem_rdata;
              mem_req_q <= 1'b0;
              state     <= IF_DONE;
            end
          end
          IF_DONE: begin
            if (!stall[StallPc]) begin
              pc    <= pc + PcStep;
              state <= IF_IDLE;
            end
          end
          default: begin
            if (mem.mem_ack) begin
              mem_req_q <= 1'b0;
              state     <= IF_IDLE;
            end
          end
        endcase
      end
    end
  end

  // NOTE: presentation outputs are decoded from registered state with every
  // output assigned on every path, so no latch is inferred.
  assign stallreq_if = (state != IF_DONE);
  assign if_pc       = (state == IF_DONE) ? pc : ZeroWord;
  assign if_inst     = (state == IF_DONE) ? inst_buf : ZeroWord;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// checked against an instruction-stream reference model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam addr_t RESET_PC = 32'h0000_0000;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      rdy = 1'b1;
  logic      jump_flag = 1'b0;
  logic [5:0] stall = '0;
  addr_t     jump_target = '0;
  logic      stallreq_if;
  addr_t     if_pc;
  inst_t     if_inst;

  if_fetch_if mem_bus();

  if_fetch #(.RESET_PC(RESET_PC), .ICACHE_LINES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .stall      (stall),
    .jump_flag  (jump_flag),
    .jump_target(jump_target),
    .mem        (mem_bus),
    .stallreq_if(stallreq_if),
    .if_pc      (if_pc),
    .if_inst    (if_inst)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  addr_t exp_pc;
  int    consumed = 0;
  bit    auto_mem = 1'b0;
  bit    real_ack = 1'b0;
  int    lat_cnt  = 0;
  int    mem_lat  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  // Memory image: a fixed scramble of the address, distinct per word.
  function automatic inst_t word_at(input addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: the model consumes the pre-edge view, then outputs are checked.
  task automatic cycle();
    logic  rdy_s, jmp_s, st0_s, pres_s, req_s;
    addr_t tgt_s, addr_s;
    rdy_s  = rdy;
    jmp_s  = jump_flag;
    st0_s  = stall[StallPc];
    tgt_s  = jump_target;
    pres_s = !stallreq_if;
    req_s  = mem_bus.mem_req;
    addr_s = mem_bus.mem_addr;
    @(posedge clk);
    #1;
    if (rdy_s) begin
      if (jmp_s) exp_pc = {tgt_s[31:2], 2'b00};
      else if (pres_s && !st0_s) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    if (!stallreq_if) begin
      check("pres_pc", if_pc, exp_pc);
      check("pres_inst", if_inst, word_at(exp_pc));
    end else begin
      check("bubble_pc", if_pc, 32'h0);
      check("bubble_inst", if_inst, 32'h0);
    end
    if (mem_bus.mem_req && req_s) check("addr_stable", mem_bus.mem_addr, addr_s);
    if (mem_bus.mem_req && !req_s) check("req_addr", mem_bus.mem_addr, exp_pc);
    if (auto_mem) begin
      if (!mem_bus.mem_req) begin
        // Spurious acks while no request is outstanding must be ignored.
        lat_cnt           = 0;
        real_ack          = 1'b0;
        mem_lat           = $urandom_range(0, 3);
        mem_bus.mem_ack   = ($urandom_range(0, 7) == 0);
        mem_bus.mem_rdata = $urandom;
      end else if (!real_ack) begin
        if (lat_cnt >= mem_lat) begin
          real_ack          = 1'b1;
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = word_at(mem_bus.mem_addr);
        end else begin
          lat_cnt++;
          mem_bus.mem_ack   = 1'b0;
          mem_bus.mem_rdata = $urandom;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rdy = 1'b1;
    stall = '0;
    jump_flag = 1'b0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    #1;
    check("rst_req", mem_bus.mem_req, 32'h0);
    check("rst_addr", mem_bus.mem_addr, 32'h0);
    check("rst_stallreq", stallreq_if, 32'h1);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    exp_pc   = RESET_PC;
    real_ack = 1'b0;
    lat_cnt  = 0;
  endtask

  task automatic ack_with(input inst_t data);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = data;
    cycle();
    mem_bus.mem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset release and first fetch with memory latency 3.
    apply_reset();
    cycle();
    check("a_req", mem_bus.mem_req, 32'h1);
    check("a_addr", mem_bus.mem_addr, RESET_PC);
    repeat (2) cycle();
    ack_with(word_at(32'h0));
    check("a_stallreq", stallreq_if, 32'h0);
    check("a_if_pc", if_pc, 32'h0);
    check("a_if_inst", if_inst, word_at(32'h0));
    cycle();
    cycle();
    check("a_next_addr", mem_bus.mem_addr, 32'h4);

    // PC hold in DONE for 5 cycles.
    ack_with(word_at(32'h4));
    stall[StallPc] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("b_hold_pc", if_pc, 32'h4);
      check("b_hold_inst", if_inst, word_at(32'h4));
    end
    stall[StallPc] = 1'b0;
    cycle();
    check("b_release_stallreq", stallreq_if, 32'h1);
    cycle();
    check("b_next_addr", mem_bus.mem_addr, 32'h8);

    // Redirect during WAIT, ack arrives later and must be dropped.
    jump_flag = 1'b1;
    jump_target = 32'h0000_0100;
    cycle();
    jump_flag = 1'b0;
    check("c_discard_req", mem_bus.mem_req, 32'h1);
    cycle();
    ack_with(32'hDEAD_BEEF);
    check("c_drop_req", mem_bus.mem_req, 32'h0);
    check("c_drop_stallreq", stallreq_if, 32'h1);
    cycle();
    check("c_refetch_addr", mem_bus.mem_addr, 32'h100);
    ack_with(word_at(32'h100));
    check("c_pres_inst", if_inst, word_at(32'h100));
    cycle();
    cycle();
    check("c2_addr", mem_bus.mem_addr, 32'h104);

    // Redirect and ack in the same cycle.
    jump_flag = 1'b1;
    jump_target = 32'h0000_0202;
    ack_with(32'hDEAD_BEEF);
    jump_flag = 1'b0;
    check("c2_drop_req", mem_bus.mem_req, 32'h0);
    check("c2_drop_stallreq", stallreq_if, 32'h1);
    cycle();
    check("c2_refetch_addr", mem_bus.mem_addr, 32'h200);

    // rdy low freezes the stage while an ack is pending.
    rdy = 1'b0;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = word_at(32'h200);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("d_frozen_stallreq", stallreq_if, 32'h1);
      check("d_frozen_req", mem_bus.mem_req, 32'h1);
    end
    rdy = 1'b1;
    cycle();
    mem_bus.mem_ack = 1'b0;
    check("d_capture_pc", if_pc, 32'h200);
    check("d_capture_inst", if_inst, word_at(32'h200));

    // Asynchronous reset pulse in the middle of a WAIT.
    cycle();
    cycle();
    check("e_wait_addr", mem_bus.mem_addr, 32'h204);
    #3;
    apply_reset();
    cycle();
    check("e_first_req", mem_bus.mem_req, 32'h1);
    check("e_first_addr", mem_bus.mem_addr, RESET_PC);

`ifdef IF_ICACHE_EN
    // Four-instruction loop: second pass must hit with no memory traffic.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        cycle();
        check("f_miss_addr", mem_bus.mem_addr, 32'(i * 4));
      end
      ack_with(word_at(32'(i * 4)));
      if (i < 3) cycle();
    end
    jump_flag = 1'b1;
    jump_target = 32'h0;
    cycle();
    jump_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("f_hit_noreq", mem_bus.mem_req, 32'h0);
      check("f_hit_stallreq", stallreq_if, 32'h0);
      check("f_hit_pc", if_pc, 32'(i * 4));
      if (i < 3) cycle();
    end
`endif

    // Randomized run against the instruction-stream model.
    auto_mem = 1'b1;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      stall = 6'($urandom);
      stall[StallPc] = ($urandom_range(0, 3) == 0);
      jump_flag = ($urandom_range(0, 11) == 0);
      jump_target = $urandom & 32'h0000_0FFF;
      cycle();
    end
    rdy = 1'b1;
    jump_flag = 1'b0;
    stall = '0;
    repeat (20) cycle();
    check("progress", 32'(consumed >= 100), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues word-fetch requests to the memory controller.
- Holds the returned instruction and presents if_pc/if_inst for the IF/ID register to latch.
- Raises a stall request while a fetch is outstanding; accepts redirects (branch/jump resolution) from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ICACHE_LINES, 64, direct-mapped I-cache entries (power of 2; used only with IF_ICACHE_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; 0 freezes all state
stall  in  6  pipeline stall vector; bit0 = PC hold, bit1 = IF hold
jump_flag  in  1  redirect request from EX (flush)
jump_target  in  32  redirect PC
mem_ack  in  1  memory controller: fetch word returned this cycle
mem_rdata  in  32  fetched instruction word (little-endian assembled)
mem_req  out  1  fetch request, held until mem_ack
mem_addr  out  32  fetch address (word aligned)
stallreq_if  out  1  IF stall request to the stall controller
if_pc  out  32  PC of the presented instruction
if_inst  out  32  presented instruction

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=IDLE, inst_buf=0, mem_req=0, mem_addr=0, stallreq_if=1, if_pc=0, if_inst=0. All cache valid bits are cleared.
- rdy=0: no register changes; outputs hold.
- States are IDLE, WAIT, DONE, DISCARD.
- IDLE:
  - assert mem_req=1, mem_addr=pc;
  - go to WAIT next cycle;
  - stallreq_if=1.
- WAIT:
  - mem_req stays 1, and mem_addr stays stable until mem_ack;
  - on mem_ack: inst_buf<=mem_rdata, mem_req<=0, go to DONE;
  - stallreq_if=1.
- DONE:
  - stallreq_if=0, if_pc=pc, if_inst=inst_buf;
  - if stall[0]=0: pc<=pc+4 (mod 2^32 wrap), go to IDLE;
  - else hold.
  - Minimum fetch-to-present latency is 2 cycles plus memory latency.
- Redirect (jump_flag=1) has priority over all other events in every state; pc<=jump_target.
  - From IDLE/DONE: go to IDLE.
  - From WAIT with no mem_ack that cycle: go to DISCARD, keep mem_req until ack, then drop the returned data and go to IDLE.
  - From WAIT with mem_ack in the same cycle: drop the data and go to IDLE.
  - In DISCARD, a further jump_flag updates pc only.
- During IDLE/WAIT/DISCARD, if_inst=0 and if_pc=0, so a bubble (NOP-equivalent zero) is presented if IF/ID is not stalled.
- jump_target[1:0] is ignored; it is forced to 0.
- mem_ack outside WAIT/DISCARD is ignored.

Optional Feature:
- Macro: IF_ICACHE_EN.
- Defined:
  - Direct-mapped cache with ICACHE_LINES words, indexed by pc[log2(LINES)+1:2]; tag is the remaining upper PC bits.
  - In IDLE on a hit: inst_buf<=line, go to DONE with no mem_req (1-cycle hit path).
  - Every accepted mem_ack in WAIT writes the line and sets valid; acks dropped in DISCARD do not write.
  - Reset clears all valid bits.
- Undefined: every fetch goes to memory; no cache storage is instantiated.

Decomposition:
- Shared config package holds:
  - Addrlen=32, Instlen=32, ZeroWord;
  - ResetEnable (1'b0, active-low);
  - fetch-state encodings IF_IDLE/IF_WAIT/IF_DONE/IF_DISCARD;
  - stall-bit indices.
- One natural sub-module, if_icache:
  - storage plus tag compare;
  - ports: lookup addr, hit, rdata, write enable/addr/data;
  - instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset release, memory ack latency 3 → mem_req=1 with mem_addr=0 one cycle after reset deasserts. After the ack, if_pc=0 and if_inst=mem_rdata; the next mem_addr is 4.
- stall[0]=1 held 5 cycles in DONE → if_pc/if_inst stable and pc unchanged; the fetch of pc+4 starts the cycle after release.
- jump_flag with target 0x100 during WAIT, ack 2 cycles later with 0xDEADBEEF → the data is never presented; the next mem_addr is 0x100. The same test with jump_flag and mem_ack in the same cycle gives identical results.
- rdy=0 for 3 cycles mid-WAIT with mem_ack asserted → no capture while rdy=0; the capture happens on the first rdy=1 cycle with ack.
- IF_ICACHE_EN, 4-instruction loop at 0x0 jumping back via jump_flag → the second iteration shows no mem_req and 1-cycle IDLE→DONE per instruction.
- Asynchronous rst pulse mid-WAIT (not clock aligned) → all outputs immediately return to reset values; the first request after release is to RESET_PC.
